// File: rtl/stage1_fetch.sv
// S1 fetch stage: owns the PC, issues one imem request at a time and loads the S1->S2 register.
// Optional: define FETCH_MISALIGN_EN to flag misaligned redirect targets instead of aligning them.
module stage1_fetch #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk_i,
  input  logic            rst_n_i,
  input  logic            pc_src_s3_i,
  input  logic [XLEN-1:0] pc_target_s3_i,
  input  logic            stall_s1_i,
  output logic            imem_req_o,
  output logic [XLEN-1:0] imem_addr_o,
  input  logic            imem_gnt_i,
  input  logic            imem_rvalid_i,
  input  logic [31:0]     imem_rdata_i,
  output logic            valid_s2_o,
  output logic [31:0]     instr_s2_o,
  output logic [XLEN-1:0] pc_s2_o,
  output logic [XLEN-1:0] pc_plus4_s2_o,
  output logic            misalign_s2_o
);

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [2:0] {IDLE, REQ, WAIT, HOLD, DROP} state_t;

  state_t          state_reg, state_next;
  logic [XLEN-1:0] pc_reg, pc_next;
  logic [31:0]     hold_reg, hold_next;
  logic            bad_reg, bad_next;
  logic            bad_done_reg, bad_done_next;
  logic            valid_reg;
  logic [31:0]     instr_reg;
  logic [XLEN-1:0] pc_s2_reg, pc4_reg;
  logic            mis_reg;

  logic            load;
  logic [31:0]     load_instr;
  logic            load_mis;
  logic            req;
  logic [XLEN-1:0] pc_plus4;
  logic [XLEN-1:0] target;
  logic            target_bad;

`ifdef FETCH_MISALIGN_EN
  assign target     = pc_target_s3_i;
  assign target_bad = |pc_target_s3_i[1:0];
`else
  logic [1:0] unused_target_lsb;
  assign unused_target_lsb = pc_target_s3_i[1:0];
  assign target     = {pc_target_s3_i[XLEN-1:2], 2'b00};
  assign target_bad = 1'b0;
`endif

  assign pc_plus4    = pc_reg + XLEN'(4);
  // A pc known to be misaligned is never put on the bus.
  assign req         = (state_reg == REQ) && !bad_reg;
  assign imem_req_o  = req;
  assign imem_addr_o = pc_reg;

  always_comb begin
    state_next    = state_reg;
    pc_next       = pc_reg;
    hold_next     = hold_reg;
    bad_next      = bad_reg;
    bad_done_next = bad_done_reg;
    load          = 1'b0;
    load_instr    = hold_reg;
    load_mis      = 1'b0;

    case (state_reg)
      IDLE: state_next = REQ;
      REQ: begin
        if (bad_reg) begin
          if (!bad_done_reg && !stall_s1_i) begin
            load          = 1'b1;
            load_instr    = NOP;
            load_mis      = 1'b1;
            bad_done_next = 1'b1;
          end
        end else if (imem_gnt_i) begin
          state_next = WAIT;
        end
      end
      WAIT: begin
        if (imem_rvalid_i) begin
          if (stall_s1_i) begin
            hold_next  = imem_rdata_i;
            state_next = HOLD;
          end else begin
            load       = 1'b1;
            load_instr = imem_rdata_i;
            pc_next    = pc_plus4;
            state_next = REQ;
          end
        end
      end
      HOLD: begin
        if (!stall_s1_i) begin
          load       = 1'b1;
          pc_next    = pc_plus4;
          state_next = REQ;
        end
      end
      DROP: if (imem_rvalid_i) state_next = REQ;
      default: state_next = IDLE;
    endcase

    // Flush beats stall. A request granted in the redirect cycle still owes a
    // response, so it must be drained in DROP just like an outstanding WAIT.
    if (pc_src_s3_i) begin
      load          = 1'b0;
      pc_next       = target;
      bad_next      = target_bad;
      bad_done_next = 1'b0;
      case (state_reg)
        WAIT:    state_next = imem_rvalid_i ? REQ : DROP;
        REQ:     state_next = (req && imem_gnt_i) ? DROP : REQ;
        DROP:    state_next = DROP;
        default: state_next = REQ;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_reg    <= IDLE;
      pc_reg       <= RESET_PC;
      hold_reg     <= '0;
      bad_reg      <= 1'b0;
      bad_done_reg <= 1'b0;
      valid_reg    <= 1'b0;
      instr_reg    <= NOP;
      pc_s2_reg    <= '0;
      pc4_reg      <= '0;
      mis_reg      <= 1'b0;
    end else begin
      state_reg    <= state_next;
      pc_reg       <= pc_next;
      hold_reg     <= hold_next;
      bad_reg      <= bad_next;
      bad_done_reg <= bad_done_next;
      if (load) begin
        valid_reg <= 1'b1;
        instr_reg <= load_instr;
        pc_s2_reg <= pc_reg;
        pc4_reg   <= pc_plus4;
        mis_reg   <= load_mis;
      end else if (pc_src_s3_i || !stall_s1_i) begin
        valid_reg <= 1'b0;
      end
    end
  end

  assign valid_s2_o    = valid_reg;
  assign instr_s2_o    = instr_reg;
  assign pc_s2_o       = pc_s2_reg;
  assign pc_plus4_s2_o = pc4_reg;
  assign misalign_s2_o = mis_reg;

endmodule

// File: tb/tb_stage1_fetch.sv
// Self-checking bench for stage1_fetch: directed sequences, a redirect table and a
// randomized run checked against an instruction-stream model.
module tb_stage1_fetch;

  localparam logic [31:0] RST_PC = 32'h0000_0100;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic        clk_i = 1'b0;
  logic        rst_n_i;
  logic        pc_src_s3_i;
  logic [31:0] pc_target_s3_i;
  logic        stall_s1_i;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i;
  logic        imem_rvalid_i;
  logic [31:0] imem_rdata_i;
  logic        valid_s2_o;
  logic [31:0] instr_s2_o;
  logic [31:0] pc_s2_o;
  logic [31:0] pc_plus4_s2_o;
  logic        misalign_s2_o;

  int checks = 0;
  int errors = 0;

  // memory responder knobs
  bit          gnt_rand = 1'b0;
  bit          spur_en  = 1'b0;
  int          rv_min   = 1;
  int          rv_max   = 1;
  int          pend     = 0;
  logic [31:0] pend_addr = '0;

  typedef struct {
    logic [31:0] target;
    logic        exp_req;
    logic [31:0] exp_addr;
    logic [31:0] exp_pc;
    logic [31:0] exp_pc4;
    logic        exp_mis;
    logic [31:0] exp_next;
  } vec_t;
  vec_t vt [5];

  stage1_fetch #(.XLEN(32), .RESET_PC(RST_PC)) dut (
    .clk_i         (clk_i),
    .rst_n_i       (rst_n_i),
    .pc_src_s3_i   (pc_src_s3_i),
    .pc_target_s3_i(pc_target_s3_i),
    .stall_s1_i    (stall_s1_i),
    .imem_req_o    (imem_req_o),
    .imem_addr_o   (imem_addr_o),
    .imem_gnt_i    (imem_gnt_i),
    .imem_rvalid_i (imem_rvalid_i),
    .imem_rdata_i  (imem_rdata_i),
    .valid_s2_o    (valid_s2_o),
    .instr_s2_o    (instr_s2_o),
    .pc_s2_o       (pc_s2_o),
    .pc_plus4_s2_o (pc_plus4_s2_o),
    .misalign_s2_o (misalign_s2_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hC3A5_5A3C;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk_i);
    #1;
  endtask

  task automatic wait_grant(input string name, input logic [31:0] exp_addr);
    int n = 0;
    while (!(imem_req_o && imem_gnt_i) && n < 60) begin
      tick();
      n++;
    end
    chk({name, "_tmo"}, 32'(n < 60), 32'd1);
    chk(name, imem_addr_o, exp_addr);
  endtask

  task automatic wait_valid(input string name, input logic [31:0] exp_pc, input logic [31:0] exp_pc4,
                            input logic exp_mis, input logic [31:0] exp_instr);
    int n = 0;
    tick();
    while (!valid_s2_o && n < 60) begin
      tick();
      n++;
    end
    chk({name, "_tmo"}, 32'(n < 60), 32'd1);
    chk({name, "_pc"}, pc_s2_o, exp_pc);
    chk({name, "_instr"}, instr_s2_o, exp_instr);
    chk({name, "_pc4"}, pc_plus4_s2_o, exp_pc4);
    chk({name, "_mis"}, 32'(misalign_s2_o), 32'(exp_mis));
  endtask

  // Single-outstanding memory: grants only when no response is owed.
  initial begin
    imem_gnt_i    = 1'b0;
    imem_rvalid_i = 1'b0;
    imem_rdata_i  = '0;
    forever begin
      @(negedge clk_i);
      imem_rvalid_i = 1'b0;
      if (pend > 0) begin
        pend--;
        if (pend == 0) begin
          imem_rvalid_i = 1'b1;
          imem_rdata_i  = instr_of(pend_addr);
        end
      end else if (spur_en && $urandom_range(0, 9) == 0) begin
        imem_rvalid_i = 1'b1;
        imem_rdata_i  = 32'hDEAD_BEEF;
      end
      imem_gnt_i = 1'b0;
      if (imem_req_o && pend == 0 && (!gnt_rand || $urandom_range(0, 2) != 0)) begin
        imem_gnt_i = 1'b1;
        pend       = int'($urandom_range(rv_min, rv_max));
        pend_addr  = imem_addr_o;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] exp_pc, mpc, prev_target, tgt;
    logic        mvalid, prev_redir, prev_stall;
    int          deliveries, nreq;

    vt[0] = '{32'h0000_0200, 1'b1, 32'h0000_0200, 32'h0000_0200, 32'h0000_0204, 1'b0, 32'h0000_0204};
`ifdef FETCH_MISALIGN_EN
    vt[1] = '{32'h0000_0402, 1'b0, 32'h0000_0000, 32'h0000_0402, 32'h0000_0406, 1'b1, 32'h0000_0000};
`else
    vt[1] = '{32'h0000_0402, 1'b1, 32'h0000_0400, 32'h0000_0400, 32'h0000_0404, 1'b0, 32'h0000_0404};
`endif
    vt[2] = '{32'hFFFF_FFFC, 1'b1, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'h0000_0000, 1'b0, 32'h0000_0000};
    vt[3] = '{32'h0000_1000, 1'b1, 32'h0000_1000, 32'h0000_1000, 32'h0000_1004, 1'b0, 32'h0000_1004};
    vt[4] = '{32'h8000_0000, 1'b1, 32'h8000_0000, 32'h8000_0000, 32'h8000_0004, 1'b0, 32'h8000_0004};

    rst_n_i        = 1'b0;
    pc_src_s3_i    = 1'b0;
    pc_target_s3_i = '0;
    stall_s1_i     = 1'b0;
    repeat (3) tick();

    chk("rst_req", 32'(imem_req_o), 32'd0);
    chk("rst_valid", 32'(valid_s2_o), 32'd0);
    chk("rst_instr", instr_s2_o, NOP);
    chk("rst_pc", pc_s2_o, 32'd0);
    chk("rst_pc4", pc_plus4_s2_o, 32'd0);
    chk("rst_mis", 32'(misalign_s2_o), 32'd0);

    // Reset release: one IDLE bubble, then back-to-back fetches every 2 cycles.
    rst_n_i = 1'b1;
    chk("rel_req", 32'(imem_req_o), 32'd0);
    tick();
    chk("first_req", 32'(imem_req_o), 32'd1);
    chk("first_addr", imem_addr_o, RST_PC);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("seq_bubble", 32'(valid_s2_o), 32'd0);
      tick();
      chk("seq_valid", 32'(valid_s2_o), 32'd1);
      chk("seq_pc", pc_s2_o, RST_PC + 32'(4 * k));
      chk("seq_instr", instr_s2_o, instr_of(RST_PC + 32'(4 * k)));
      chk("seq_pc4", pc_plus4_s2_o, RST_PC + 32'(4 * k + 4));
    end

    // Redirect while waiting on a slow response: stale word must be dropped.
    rv_min = 3; rv_max = 3;
    tick();
    wait_grant("t2_pre", 32'h0000_0110);
    tick();
    pc_src_s3_i = 1'b1; pc_target_s3_i = 32'h0000_0200;
    tick();
    pc_src_s3_i = 1'b0;
    chk("t2_flush", 32'(valid_s2_o), 32'd0);
    chk("t2_noreq", 32'(imem_req_o), 32'd0);
    wait_grant("t2_addr", 32'h0000_0200);
    wait_valid("t2_s2", 32'h0000_0200, 32'h0000_0204, 1'b0, instr_of(32'h0000_0200));

    // Redirect in the same cycle as rvalid: word discarded, new request at once.
    rv_min = 2; rv_max = 2;
    wait_valid("t3_pre", 32'h0000_0204, 32'h0000_0208, 1'b0, instr_of(32'h0000_0204));
    tick();
    tick();
    pc_src_s3_i = 1'b1; pc_target_s3_i = 32'h0000_0300;
    tick();
    pc_src_s3_i = 1'b0;
    chk("t3_flush", 32'(valid_s2_o), 32'd0);
    chk("t3_req", 32'(imem_req_o), 32'd1);
    wait_grant("t3_addr", 32'h0000_0300);
    wait_valid("t3_s2", 32'h0000_0300, 32'h0000_0304, 1'b0, instr_of(32'h0000_0300));

    // Four stalled cycles spanning the response: S2 holds, word is buffered.
    stall_s1_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t4_hold_valid", 32'(valid_s2_o), 32'd1);
      chk("t4_hold_pc", pc_s2_o, 32'h0000_0300);
    end
    stall_s1_i = 1'b0;
    tick();
    chk("t4_rel_valid", 32'(valid_s2_o), 32'd1);
    chk("t4_rel_pc", pc_s2_o, 32'h0000_0304);
    chk("t4_rel_instr", instr_s2_o, instr_of(32'h0000_0304));
    wait_grant("t4_next", 32'h0000_0308);

    // Redirect under stall still flushes.
    stall_s1_i = 1'b1;
    pc_src_s3_i = 1'b1; pc_target_s3_i = 32'h0000_0500;
    tick();
    pc_src_s3_i = 1'b0;
    chk("t5_flush", 32'(valid_s2_o), 32'd0);
    tick();
    stall_s1_i = 1'b0;
    wait_grant("t5_addr", 32'h0000_0500);
    wait_valid("t5_s2", 32'h0000_0500, 32'h0000_0504, 1'b0, instr_of(32'h0000_0500));

    // Redirect target table.
    for (int i = 0; i < 5; i++) begin
      pc_src_s3_i = 1'b1; pc_target_s3_i = vt[i].target;
      tick();
      pc_src_s3_i = 1'b0;
      chk("tbl_flush", 32'(valid_s2_o), 32'd0);
      if (vt[i].exp_req) begin
        wait_grant("tbl_addr", vt[i].exp_addr);
        wait_valid("tbl_s2", vt[i].exp_pc, vt[i].exp_pc4, vt[i].exp_mis, instr_of(vt[i].exp_pc));
        wait_valid("tbl_next", vt[i].exp_next, vt[i].exp_next + 32'd4, 1'b0, instr_of(vt[i].exp_next));
      end else begin
        wait_valid("tbl_mis", vt[i].exp_pc, vt[i].exp_pc4, vt[i].exp_mis, NOP);
        nreq = 0;
        for (int j = 0; j < 10; j++) begin
          tick();
          if (imem_req_o) nreq++;
        end
        chk("tbl_idle", 32'(nreq), 32'd0);
      end
    end

    // Async reset in the middle of a WAIT; the late response must be ignored.
    rv_min = 4; rv_max = 4;
    tick();
    wait_grant("t7_pre", 32'h8000_000C);
    tick();
    rst_n_i = 1'b0;
    #1;
    chk("t7_rst_req", 32'(imem_req_o), 32'd0);
    chk("t7_rst_valid", 32'(valid_s2_o), 32'd0);
    chk("t7_rst_instr", instr_s2_o, NOP);
    chk("t7_rst_pc", pc_s2_o, 32'd0);
    chk("t7_rst_pc4", pc_plus4_s2_o, 32'd0);
    tick();
    tick();
    rst_n_i = 1'b1;
    wait_valid("t7_after", RST_PC, RST_PC + 32'd4, 1'b0, instr_of(RST_PC));

    // Randomized run against a stream model: the delivered instructions must be
    // the sequential PC stream from reset, restarted at each redirect target.
    gnt_rand = 1'b1; spur_en = 1'b1; rv_min = 1; rv_max = 4;
    rst_n_i = 1'b0;
    tick();
    tick();
    rst_n_i = 1'b1;
    exp_pc = RST_PC; mpc = '0; mvalid = 1'b0; deliveries = 0;
    prev_redir = 1'b0; prev_stall = 1'b0; prev_target = '0;
    for (int c = 0; c < 3000; c++) begin
      tick();
      if (prev_redir) begin
        chk("rnd_flush", 32'(valid_s2_o), 32'd0);
        mvalid = 1'b0;
        exp_pc = prev_target & 32'hFFFF_FFFC;
      end else if (prev_stall) begin
        chk("rnd_hold_valid", 32'(valid_s2_o), 32'(mvalid));
        if (mvalid) begin
          chk("rnd_hold_pc", pc_s2_o, mpc);
          chk("rnd_hold_instr", instr_s2_o, instr_of(mpc));
        end
      end else if (valid_s2_o) begin
        chk("rnd_pc", pc_s2_o, exp_pc);
        chk("rnd_instr", instr_s2_o, instr_of(exp_pc));
        chk("rnd_pc4", pc_plus4_s2_o, exp_pc + 32'd4);
        chk("rnd_mis", 32'(misalign_s2_o), 32'd0);
        mpc = exp_pc;
        exp_pc = exp_pc + 32'd4;
        mvalid = 1'b1;
        deliveries++;
      end else begin
        mvalid = 1'b0;
      end
      if (imem_req_o && imem_gnt_i) chk("rnd_gnt_addr", imem_addr_o, exp_pc);
      stall_s1_i  = ($urandom_range(0, 3) == 0);
      pc_src_s3_i = ($urandom_range(0, 29) == 0);
      tgt = $urandom();
`ifdef FETCH_MISALIGN_EN
      tgt[1:0] = 2'b00;
`endif
      pc_target_s3_i = tgt;
      prev_redir  = pc_src_s3_i;
      prev_stall  = stall_s1_i;
      prev_target = tgt;
    end
    chk("rnd_live", 32'(deliveries >= 150), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
